// File: rtl/pp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pp_pkg                                                       |
// | Description : Shared types and helpers for the packet header parser:       |
// |               parser state encoding, default word size in bytes and a      |
// |               small integer max helper for elaboration-time sizing.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pp_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ETH   = 3'd1,
    IP    = 3'd2,
    TCP   = 3'd3,
    PAY   = 3'd4,
    DRAIN = 3'd5
  } pp_state_t;

  // Bytes per word at the default 32-bit data width. Parametrised instances
  // derive their own value from WIDTH.
  localparam int BYTES = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pp_skid_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pp_skid_buf                                                  |
// | Description : Two-entry registered valid/ready skid buffer. Upstream ready |
// |               comes straight from a flop, output is registered, and a      |
// |               second entry catches the word in flight when downstream      |
// |               stalls, so full throughput is kept without a comb path.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, rst   clock, synchronous active-high reset                          |
// |   i_data     W-bit word in          i_valid  word in valid                 |
// |   o_ready    buffer can take a word this cycle (skid entry empty)          |
// |   o_data     W-bit word out         o_valid  word out valid                |
// |   i_ready    downstream accepts o_data                                     |
// +----------------------------------------------------------------------------+
module pp_skid_buf #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready
);

  logic [W-1:0] r_out_data;
  logic [W-1:0] r_skid_data;
  logic         r_out_valid;
  logic         r_skid_valid;
  logic         w_out_free;
  logic         w_push;

  assign o_ready    = !r_skid_valid;
  assign w_push     = i_valid && !r_skid_valid;
  assign w_out_free = !r_out_valid || i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data   <= '0;
      r_skid_data  <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      // Oldest word first: a parked skid word always beats new input, and
      // new input cannot arrive while the skid entry is occupied.
      if (r_skid_valid) begin
        r_out_data   <= r_skid_data;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= w_push;
        if (w_push) begin
          r_out_data <= i_data;
        end
      end
    end else if (w_push) begin
      r_skid_data  <= i_data;
      r_skid_valid <= 1'b1;
    end
  end

  assign o_data  = r_out_data;
  assign o_valid = r_out_valid;

endmodule
`default_nettype wire

// File: rtl/pkt_hdr_parser_len.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pkt_hdr_parser_len                                           |
// | Description : Strips Ethernet/IP/TCP headers of configurable word counts   |
// |               from an inbound word stream, captures them, and forwards the |
// |               payload through a skid buffer. Payload length comes from the |
// |               IP total-length field; last_in is checked against it.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, rst                clock, synchronous active-high reset             |
// |   data_in/valid_in/last_in/ready_in   inbound word stream                  |
// |   data_out/valid_out/last_out/ready_out  payload stream to the FIFO        |
// |   eth_hdr/ip_hdr/tcp_hdr  captured headers, first word in the MSBs         |
// |   hdr_valid               1-cycle pulse, all headers stable                |
// |   err_short/err_long/err_len  1-cycle error pulses                         |
// +----------------------------------------------------------------------------+
module pkt_hdr_parser_len
  import pp_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int ETH_WORDS     = 4,
  parameter int IP_WORDS      = 5,
  parameter int TCP_WORDS     = 5,
  parameter int LEN_WORD      = 0,
  parameter int LEN_LSB       = 0,
  parameter int MAX_PAY_WORDS = 375
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       valid_in,
  input  logic                       last_in,
  output logic                       ready_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       valid_out,
  output logic                       last_out,
  input  logic                       ready_out,
  output logic [ETH_WORDS*WIDTH-1:0] eth_hdr,
  output logic [IP_WORDS*WIDTH-1:0]  ip_hdr,
  output logic [TCP_WORDS*WIDTH-1:0] tcp_hdr,
  output logic                       hdr_valid,
  output logic                       err_short,
  output logic                       err_long,
  output logic                       err_len
);

  localparam int c_BYTES     = WIDTH / 8;
  localparam int c_ETH_HW    = ETH_WORDS * WIDTH;
  localparam int c_IP_HW     = IP_WORDS * WIDTH;
  localparam int c_TCP_HW    = TCP_WORDS * WIDTH;
  localparam int c_CNT_MAX   = max_int(max_int(ETH_WORDS, IP_WORDS),
                                       max_int(TCP_WORDS, MAX_PAY_WORDS));
  localparam int c_CW        = $clog2(c_CNT_MAX + 1);
  localparam int c_HDR_BYTES = (IP_WORDS + TCP_WORDS) * c_BYTES;

  localparam logic [c_CW-1:0] c_ONE      = c_CW'(1);
  // ETH word 0 is consumed in IDLE, so the ETH state holds words 1..N-1.
  localparam logic [c_CW-1:0] c_ETH_LAST = c_CW'((ETH_WORDS >= 2) ? ETH_WORDS - 2 : 0);
  localparam logic [c_CW-1:0] c_IP_LAST  = c_CW'(IP_WORDS - 1);
  localparam logic [c_CW-1:0] c_TCP_LAST = c_CW'(TCP_WORDS - 1);
  localparam logic [16:0]     c_HDR_B17  = 17'(c_HDR_BYTES);
  localparam logic [16:0]     c_RND17    = 17'(c_BYTES - 1);
  localparam logic [16:0]     c_BYTES17  = 17'(c_BYTES);
  localparam logic [16:0]     c_MAX17    = 17'(MAX_PAY_WORDS);

  pp_state_t             r_state;
  pp_state_t             w_state_nxt;
  logic [c_CW-1:0]       r_cnt;
  logic [c_CW-1:0]       r_pay_words;
  logic [c_ETH_HW-1:0]   r_eth_hdr;
  logic [c_IP_HW-1:0]    r_ip_hdr;
  logic [c_TCP_HW-1:0]   r_tcp_hdr;
  logic                  r_hdr_valid;
  logic                  r_err_short;
  logic                  r_err_long;
  logic                  r_err_len;

  logic                  w_accept;
  logic                  w_counting;
  logic                  w_skid_ready;
  logic                  w_push;
  logic                  w_push_last;
  logic                  w_pay_load;
  logic                  w_pay_final;
  logic                  w_hdr_valid_nxt;
  logic                  w_err_short_nxt;
  logic                  w_err_long_nxt;
  logic                  w_err_len_nxt;
  logic [c_IP_HW-1:0]    w_ip_next;
  logic [15:0]           w_len;
  logic [16:0]           w_len17;
  logic [16:0]           w_pay17;
  logic                  w_len_bad;
  logic [WIDTH:0]        w_skid_out;

  assign ready_in   = (r_state == PAY) ? w_skid_ready : 1'b1;
  assign w_accept   = valid_in && ready_in;
  assign w_counting = (r_state == ETH) || (r_state == IP) ||
                      (r_state == TCP) || (r_state == PAY);

  // The length word may be the one arriving right now, so it is read from
  // the IP header as it will look after this word is shifted in.
  assign w_ip_next = c_IP_HW'({r_ip_hdr, data_in});
  assign w_len     = w_ip_next[(IP_WORDS - 1 - LEN_WORD) * WIDTH + LEN_LSB +: 16];
  assign w_len17   = {1'b0, w_len};
  assign w_pay17   = (w_len17 - c_HDR_B17 + c_RND17) / c_BYTES17;
  assign w_len_bad = (w_len17 < c_HDR_B17) || (w_pay17 > c_MAX17);

  assign w_pay_final = (r_cnt == (r_pay_words - c_ONE));

  always_comb begin
    w_state_nxt     = r_state;
    w_push          = 1'b0;
    w_push_last     = 1'b0;
    w_pay_load      = 1'b0;
    w_hdr_valid_nxt = 1'b0;
    w_err_short_nxt = 1'b0;
    w_err_long_nxt  = 1'b0;
    w_err_len_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (last_in) begin
            w_err_short_nxt = 1'b1;
          end else if (ETH_WORDS == 1) begin
            w_state_nxt = IP;
          end else begin
            w_state_nxt = ETH;
          end
        end
      end
      ETH: begin
        if (w_accept) begin
          if (last_in) begin
            w_err_short_nxt = 1'b1;
            w_state_nxt     = IDLE;
          end else if (r_cnt == c_ETH_LAST) begin
            w_state_nxt = IP;
          end
        end
      end
      IP: begin
        if (w_accept) begin
          if (last_in) begin
            w_err_short_nxt = 1'b1;
            w_state_nxt     = IDLE;
          end else if (r_cnt == c_IP_LAST) begin
            if (w_len_bad) begin
              w_err_len_nxt = 1'b1;
              w_state_nxt   = DRAIN;
            end else begin
              w_pay_load  = 1'b1;
              w_state_nxt = TCP;
            end
          end
        end
      end
      TCP: begin
        if (w_accept) begin
          if (r_cnt == c_TCP_LAST) begin
            w_hdr_valid_nxt = 1'b1;
            if (r_pay_words == '0) begin
              if (last_in) begin
                w_state_nxt = IDLE;
              end else begin
                w_err_long_nxt = 1'b1;
                w_state_nxt    = DRAIN;
              end
            end else if (last_in) begin
              w_err_short_nxt = 1'b1;
              w_state_nxt     = IDLE;
            end else begin
              w_state_nxt = PAY;
            end
          end else if (last_in) begin
            w_err_short_nxt = 1'b1;
            w_state_nxt     = IDLE;
          end
        end
      end
      PAY: begin
        if (w_accept) begin
          w_push      = 1'b1;
          w_push_last = w_pay_final || last_in;
          if (w_pay_final) begin
            if (last_in) begin
              w_state_nxt = IDLE;
            end else begin
              w_err_long_nxt = 1'b1;
              w_state_nxt    = DRAIN;
            end
          end else if (last_in) begin
            w_err_short_nxt = 1'b1;
            w_state_nxt     = IDLE;
          end
        end
      end
      DRAIN: begin
        if (w_accept && last_in) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_pay_words <= '0;
      r_eth_hdr   <= '0;
      r_ip_hdr    <= '0;
      r_tcp_hdr   <= '0;
      r_hdr_valid <= 1'b0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
      r_err_len   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hdr_valid <= w_hdr_valid_nxt;
      r_err_short <= w_err_short_nxt;
      r_err_long  <= w_err_long_nxt;
      r_err_len   <= w_err_len_nxt;

      if (w_state_nxt != r_state) begin
        r_cnt <= '0;
      end else if (w_accept && w_counting) begin
        r_cnt <= r_cnt + c_ONE;
      end

      if (w_pay_load) begin
        r_pay_words <= c_CW'(w_pay17);
      end

      if (w_accept) begin
        case (r_state)
          IDLE, ETH: r_eth_hdr <= c_ETH_HW'({r_eth_hdr, data_in});
          IP:        r_ip_hdr  <= w_ip_next;
          TCP:       r_tcp_hdr <= c_TCP_HW'({r_tcp_hdr, data_in});
          default:   ;
        endcase
      end
    end
  end

  pp_skid_buf #(
    .W (WIDTH + 1)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_data  ({w_push_last, data_in}),
    .i_valid (w_push),
    .o_ready (w_skid_ready),
    .o_data  (w_skid_out),
    .o_valid (valid_out),
    .i_ready (ready_out)
  );

  assign data_out  = w_skid_out[WIDTH-1:0];
  assign last_out  = w_skid_out[WIDTH];
  assign eth_hdr   = r_eth_hdr;
  assign ip_hdr    = r_ip_hdr;
  assign tcp_hdr   = r_tcp_hdr;
  assign hdr_valid = r_hdr_valid;
  assign err_short = r_err_short;
  assign err_long  = r_err_long;
  assign err_len   = r_err_len;

endmodule
`default_nettype wire

// File: tb/tb_pkt_hdr_parser_len.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pkt_hdr_parser_len                                        |
// | Description : Directed self-checking bench for pkt_hdr_parser_len with     |
// |               default parameters (4/5/5 header words, 32-bit words).       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pkt_hdr_parser_len;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   data_in = '0;
  logic          valid_in = 1'b0;
  logic          last_in = 1'b0;
  logic          ready_in;
  logic [31:0]   data_out;
  logic          valid_out;
  logic          last_out;
  logic          ready_out = 1'b1;
  logic [127:0]  eth_hdr;
  logic [159:0]  ip_hdr;
  logic [159:0]  tcp_hdr;
  logic          hdr_valid;
  logic          err_short;
  logic          err_long;
  logic          err_len;

  int n_tests = 0;
  int n_fail  = 0;

  // 0: ready_out always 1, 1: toggle every cycle, 2: hold 0
  int rdy_mode = 0;

  logic [32:0] out_q[$];
  int          n_hdr, n_short, n_long, n_lenerr, n_stab;
  logic        prev_stall = 1'b0;
  logic [32:0] prev_word  = '0;

  pkt_hdr_parser_len dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .last_in   (last_in),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .last_out  (last_out),
    .ready_out (ready_out),
    .eth_hdr   (eth_hdr),
    .ip_hdr    (ip_hdr),
    .tcp_hdr   (tcp_hdr),
    .hdr_valid (hdr_valid),
    .err_short (err_short),
    .err_long  (err_long),
    .err_len   (err_len)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       ready_out = 1'b1;
      1:       ready_out = ~ready_out;
      default: ready_out = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall && (!valid_out || ({last_out, data_out} !== prev_word))) n_stab++;
      if (valid_out && ready_out) out_q.push_back({last_out, data_out});
      if (hdr_valid) n_hdr++;
      if (err_short) n_short++;
      if (err_long)  n_long++;
      if (err_len)   n_lenerr++;
    end
    prev_stall = !rst && valid_out && !ready_out;
    prev_word  = {last_out, data_out};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  task automatic clear_mon();
    out_q.delete();
    n_hdr = 0; n_short = 0; n_long = 0; n_lenerr = 0; n_stab = 0;
  endtask

  task automatic settle();
    repeat (25) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic l);
    int   n;
    logic acc;
    data_in = d; last_in = l; valid_in = 1'b1;
    n = 0; acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = ready_in;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      n_tests++; n_fail++;
      $display("FAIL send_word_timeout: ready_in stayed 0 for %0d cycles, required 1", n);
    end
  endtask

  // Word layout: 0-3 ETH, 4-8 IP (word 4 carries length), 9-13 TCP, 14+ payload.
  task automatic send_pkt(input logic [15:0] len, input int nsend, input int last_at);
    for (int i = 0; i < nsend; i++) begin
      logic [31:0] w;
      if (i < 4)       w = 32'hE000_0000 + i;
      else if (i == 4) w = {16'h4500, len};
      else if (i < 9)  w = 32'h1000_0000 + i;
      else if (i < 14) w = 32'h7000_0000 + i;
      else             w = 32'hA000_0000 + (i - 14);
      send_word(w, i == last_at);
    end
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({valid_out, last_out, data_out} !== 34'd0) begin
      n_fail++; $display("FAIL reset_out: got %h, required 0", {valid_out, last_out, data_out});
    end
    n_tests++;
    if ({hdr_valid, err_short, err_long, err_len} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_pulses: got %b, required 0000", {hdr_valid, err_short, err_long, err_len});
    end
    n_tests++;
    if ({eth_hdr, ip_hdr, tcp_hdr} !== '0) begin
      n_fail++; $display("FAIL reset_hdrs: got nonzero headers, required 0");
    end
    n_tests++;
    if (ready_in !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_in: got %b, required 1", ready_in);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [127:0] exp_eth;
    logic [159:0] exp_ip;
    logic [159:0] exp_tcp;
    clear_mon();
    send_pkt(16'd60, 19, 18);
    settle();
    exp_eth = '0; exp_ip = '0; exp_tcp = '0;
    for (int i = 0; i < 4; i++) exp_eth = {exp_eth[95:0], 32'hE000_0000 + i};
    exp_ip = {16'h4500, 16'd60, 32'h1000_0005, 32'h1000_0006, 32'h1000_0007, 32'h1000_0008};
    for (int i = 9; i < 14; i++) exp_tcp = {exp_tcp[127:0], 32'h7000_0000 + i};
    n_tests++;
    if (n_hdr !== 1) begin n_fail++; $display("FAIL basic_hdr_valid: got %0d pulses, required 1", n_hdr); end
    n_tests++;
    if (out_q.size() !== 5) begin n_fail++; $display("FAIL basic_count: got %0d words, required 5", out_q.size()); end
    for (int i = 0; i < 5 && i < out_q.size(); i++) begin
      n_tests++;
      if (out_q[i] !== {(i == 4), 32'hA000_0000 + i}) begin
        n_fail++; $display("FAIL basic_word%0d: got %h, required %h", i, out_q[i], {(i == 4), 32'hA000_0000 + i});
      end
    end
    n_tests++;
    if (n_short + n_long + n_lenerr !== 0) begin
      n_fail++; $display("FAIL basic_errors: got %0d/%0d/%0d, required 0/0/0", n_short, n_long, n_lenerr);
    end
    n_tests++;
    if (eth_hdr !== exp_eth) begin n_fail++; $display("FAIL basic_eth_hdr: got %h, required %h", eth_hdr, exp_eth); end
    n_tests++;
    if (ip_hdr !== exp_ip) begin n_fail++; $display("FAIL basic_ip_hdr: got %h, required %h", ip_hdr, exp_ip); end
    n_tests++;
    if (tcp_hdr !== exp_tcp) begin n_fail++; $display("FAIL basic_tcp_hdr: got %h, required %h", tcp_hdr, exp_tcp); end
  endtask

  task automatic test_backpressure();
    clear_mon();
    rdy_mode = 1;
    send_pkt(16'd60, 19, 18);
    settle();
    rdy_mode = 0;
    @(posedge clk); #1;
    n_tests++;
    if (out_q.size() !== 5) begin n_fail++; $display("FAIL bp_count: got %0d words, required 5", out_q.size()); end
    for (int i = 0; i < 5 && i < out_q.size(); i++) begin
      n_tests++;
      if (out_q[i] !== {(i == 4), 32'hA000_0000 + i}) begin
        n_fail++; $display("FAIL bp_word%0d: got %h, required %h", i, out_q[i], {(i == 4), 32'hA000_0000 + i});
      end
    end
    n_tests++;
    if (n_stab !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes while stalled, required 0", n_stab); end
    n_tests++;
    if (n_hdr !== 1) begin n_fail++; $display("FAIL bp_hdr_valid: got %0d pulses, required 1", n_hdr); end
  endtask

  task automatic test_short();
    clear_mon();
    send_pkt(16'd60, 17, 16);
    settle();
    n_tests++;
    if (out_q.size() !== 3) begin n_fail++; $display("FAIL short_count: got %0d words, required 3", out_q.size()); end
    for (int i = 0; i < 3 && i < out_q.size(); i++) begin
      n_tests++;
      if (out_q[i] !== {(i == 2), 32'hA000_0000 + i}) begin
        n_fail++; $display("FAIL short_word%0d: got %h, required %h", i, out_q[i], {(i == 2), 32'hA000_0000 + i});
      end
    end
    n_tests++;
    if (n_short !== 1 || n_long !== 0 || n_lenerr !== 0) begin
      n_fail++; $display("FAIL short_err: got short/long/len %0d/%0d/%0d, required 1/0/0", n_short, n_long, n_lenerr);
    end
  endtask

  task automatic test_long();
    clear_mon();
    send_pkt(16'd48, 20, 19);
    settle();
    n_tests++;
    if (out_q.size() !== 2) begin n_fail++; $display("FAIL long_count: got %0d words, required 2", out_q.size()); end
    for (int i = 0; i < 2 && i < out_q.size(); i++) begin
      n_tests++;
      if (out_q[i] !== {(i == 1), 32'hA000_0000 + i}) begin
        n_fail++; $display("FAIL long_word%0d: got %h, required %h", i, out_q[i], {(i == 1), 32'hA000_0000 + i});
      end
    end
    n_tests++;
    if (n_long !== 1 || n_short !== 0 || n_lenerr !== 0) begin
      n_fail++; $display("FAIL long_err: got short/long/len %0d/%0d/%0d, required 0/1/0", n_short, n_long, n_lenerr);
    end
    clear_mon();
    send_pkt(16'd60, 19, 18);
    settle();
    n_tests++;
    if (out_q.size() !== 5 || n_short + n_long + n_lenerr !== 0 || n_hdr !== 1) begin
      n_fail++; $display("FAIL long_next_pkt: got %0d words %0d errs %0d hdr, required 5 0 1",
                         out_q.size(), n_short + n_long + n_lenerr, n_hdr);
    end
  endtask

  task automatic test_len_bounds();
    clear_mon();
    send_pkt(16'd20, 16, 15);
    settle();
    n_tests++;
    if (n_lenerr !== 1 || n_short !== 0 || n_long !== 0) begin
      n_fail++; $display("FAIL lenerr_err: got short/long/len %0d/%0d/%0d, required 0/0/1", n_short, n_long, n_lenerr);
    end
    n_tests++;
    if (out_q.size() !== 0 || n_hdr !== 0) begin
      n_fail++; $display("FAIL lenerr_out: got %0d words %0d hdr, required 0 0", out_q.size(), n_hdr);
    end
    clear_mon();
    send_pkt(16'd40, 14, 13);
    settle();
    n_tests++;
    if (n_hdr !== 1) begin n_fail++; $display("FAIL zero_pay_hdr: got %0d pulses, required 1", n_hdr); end
    n_tests++;
    if (out_q.size() !== 0 || n_short + n_long + n_lenerr !== 0) begin
      n_fail++; $display("FAIL zero_pay_out: got %0d words %0d errs, required 0 0", out_q.size(), n_short + n_long + n_lenerr);
    end
  endtask

  task automatic test_reset_mid();
    rdy_mode = 2;
    @(posedge clk); #1;
    clear_mon();
    send_pkt(16'd60, 16, -1);
    n_tests++;
    if (valid_out !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_valid: got %b, required 1", valid_out); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++;
    if ({valid_out, last_out, data_out, hdr_valid, err_short, err_long, err_len} !== 38'd0) begin
      n_fail++; $display("FAIL rstmid_outputs: got %h, required 0",
                         {valid_out, last_out, data_out, hdr_valid, err_short, err_long, err_len});
    end
    n_tests++;
    if ({eth_hdr, ip_hdr, tcp_hdr} !== '0) begin
      n_fail++; $display("FAIL rstmid_hdrs: got nonzero headers, required 0");
    end
    rdy_mode = 0;
    @(posedge clk); #1;
    clear_mon();
    send_pkt(16'd60, 19, 18);
    settle();
    n_tests++;
    if (out_q.size() !== 5) begin n_fail++; $display("FAIL rstmid_count: got %0d words, required 5", out_q.size()); end
    for (int i = 0; i < 5 && i < out_q.size(); i++) begin
      n_tests++;
      if (out_q[i] !== {(i == 4), 32'hA000_0000 + i}) begin
        n_fail++; $display("FAIL rstmid_word%0d: got %h, required %h", i, out_q[i], {(i == 4), 32'hA000_0000 + i});
      end
    end
    n_tests++;
    if (n_hdr !== 1 || n_short + n_long + n_lenerr !== 0) begin
      n_fail++; $display("FAIL rstmid_flags: got %0d hdr %0d errs, required 1 0", n_hdr, n_short + n_long + n_lenerr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_short();
    test_long();
    test_len_bounds();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
